seven_seg_scan_ctrl: RTL and testbench
======================================

SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed display digits (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 1000, clock cycles each digit is driven per scan slot (>=1).
REQ-003 SHALL have parameter BLANK_CYCLES, default 2, anti-ghosting gap cycles between digit slots, with all anodes off (>=1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  scan enable; 0 forces display dark.
REQ-007 SHALL have port load  input  1  one-cycle strobe capturing value_in.
REQ-008 SHALL have port value_in  input  4*NUM_DIGITS  packed BCD; digit0 (least significant) = [3:0].
REQ-009 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-010 SHALL have port seg  output  7  segment pattern, same bit order/polarity as the shared decoder output.
REQ-011 SHALL have port an  output  NUM_DIGITS  one-hot active-high digit enable; an[i] drives digit i.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan.
REQ-013 SHALL have port err  output  1  sticky flag: a loaded nibble exceeded 9.

Function
REQ-014 SHALL implement FSM states IDLE, SHOW, GAP; IDLE->SHOW when enable=1; SHOW->GAP after REFRESH_DIV cycles; GAP->SHOW after BLANK_CYCLES cycles, digit index incremented.
REQ-015 SHALL wrap digit index NUM_DIGITS-1 -> 0 on GAP exit and pulse frame_done in the cycle the index wraps.
REQ-016 SHALL register seg and an; both change on the edge where the FSM enters a state (entering SHOW digit i: an = one-hot i; entering GAP/IDLE: an = 0, seg = 0).
REQ-017 SHALL capture value_in into a pending register on load=1 and set pending_valid; a second load before commit overwrites (latest wins).
REQ-018 SHALL copy pending into the display register only at frame wrap (REQ-015) when pending_valid=1, then clear pending_valid; load on the wrap cycle is committed at the next wrap.
REQ-019 SHALL, while enable=0 in IDLE, commit pending immediately, so the first frame after enable shows the latest load.
REQ-020 SHALL drive seg from one shared decoder instance, fed by the display nibble of the current digit index.
REQ-021 SHALL output seg = 0 (an still asserted) for digit i>0 when blank_lz=1 and digits i..NUM_DIGITS-1 are all zero; digit0 never blanked.
REQ-022 SHALL output seg = 0 for any displayed nibble >9, and set err on the edge after a load containing any nibble >9; err held until rst.
REQ-023 SHALL, on enable falling in any state, enter IDLE next edge: an=0, seg=0, index=0, counters cleared; re-enable starts a full slot on digit0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set state IDLE, index 0, counters 0, display and pending registers 0, pending_valid 0, err 0, seg 0, an 0, frame_done 0.
REQ-025 SHALL give rst priority over load and enable in the same cycle (value not captured).

Structure
REQ-026 SHALL place the FSM state enum and constant SEG_BLANK (7'b0) in shared package seven_seg_pkg.
REQ-027 SHALL instantiate exactly one existing bcdto7segment decoder (ports bcd, seg) as the sole sub-module.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1)
REQ-028 SHALL test reset, load 16'h1234, enable=1 -> an 0001x4, 0000x1, 0010x4, ...; seg = decode(4,3,2,1); frame_done every 20 cycles.
REQ-029 SHALL test load 16'h5678 during digit1 SHOW -> rest of frame shows 1234; frame after frame_done shows 5678.
REQ-030 SHALL test blank_lz=1, value 16'h0007 -> digits 3..1 seg=0 with an asserted, digit0 = decode(7); value 16'h0000 -> digit0 = decode(0).
REQ-031 SHALL test load 16'h00A3 -> err=1 next cycle, digit1 seg=0; later load 16'h0001 keeps err=1; rst clears it.
REQ-032 SHALL test enable=0 during digit2 SHOW -> next cycle an=0, seg=0; enable=1 -> digit0 full 4-cycle slot.
REQ-033 SHALL test rst=1 with load=1 same cycle -> all outputs 0, no value captured.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// scan FSM states, the dark segment pattern and a BCD validity helper.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } scan_state_e;

    // Segment vector bit order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    function automatic logic nibble_invalid(input logic [3:0] nibble);
        return nibble > 4'd9;
    endfunction

endpackage

// File: rtl/bcdto7segment.sv
// Shared BCD to seven-segment decoder, active-high segments {g,f,e,d,c,b,a};
// codes above 9 decode to a dark digit.
module bcdto7segment
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment display driver: scans NUM_DIGITS digits with
// blanking gaps, double-buffers loaded values and commits them at frame wrap.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    err
);

    localparam int VAL_W   = 4 * NUM_DIGITS;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYCLES - 1);

    scan_state_e           state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [VAL_W-1:0]      disp_q;
    logic [VAL_W-1:0]      pend_q;
    logic                  pend_valid_q;
    logic                  err_q;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_done_q;

    logic                  slot_end;
    logic                  wrap;
    logic                  commit;
    logic [VAL_W-1:0]      disp_d;
    logic [IDX_W-1:0]      show_idx;
    logic [NUM_DIGITS-1:0] show_an;
    logic [3:0]            show_nibble;
    logic                  upper_zero;
    logic                  lz_blank;
    logic [6:0]            dec_seg;
    logic [6:0]            show_seg;
    logic                  load_bad;

    // The segment pattern is registered on the same edge that enters SHOW, so
    // the decoder looks at the digit about to be shown and at the display
    // contents as they will be after any commit on that edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        slot_end    = (state_q == GAP) && (cnt_q == GAP_LAST);
        wrap        = enable && slot_end && (idx_q == LAST_IDX);
        commit      = pend_valid_q && (wrap || ((state_q == IDLE) && !enable));
        disp_d      = commit ? pend_q : disp_q;
        show_idx    = '0;
        if ((state_q == GAP) && (idx_q != LAST_IDX)) begin
            show_idx = idx_q + 1'b1;
        end
        show_an     = NUM_DIGITS'(1) << show_idx;
        show_nibble = '0;
        upper_zero  = 1'b1;
        load_bad    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == show_idx) begin
                show_nibble = disp_d[4*i +: 4];
            end
            if ((IDX_W'(i) >= show_idx) && (disp_d[4*i +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
            if (nibble_invalid(value_in[4*i +: 4])) begin
                load_bad = 1'b1;
            end
        end
        lz_blank = blank_lz && (show_idx != '0) && upper_zero;
        show_seg = (nibble_invalid(show_nibble) || lz_blank) ? SEG_BLANK : dec_seg;
    end

    bcdto7segment u_dec (
        .bcd (show_nibble),
        .seg (dec_seg)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
                idx_q   <= '0;
                cnt_q   <= '0;
                seg_q   <= SEG_BLANK;
                an_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= SHOW;
                        idx_q   <= show_idx;
                        cnt_q   <= '0;
                        an_q    <= show_an;
                        seg_q   <= show_seg;
                    end
                    SHOW: begin
                        if (cnt_q == SHOW_LAST) begin
                            state_q <= GAP;
                            cnt_q   <= '0;
                            an_q    <= '0;
                            seg_q   <= SEG_BLANK;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    GAP: begin
                        if (slot_end) begin
                            state_q      <= SHOW;
                            idx_q        <= show_idx;
                            cnt_q        <= '0;
                            an_q         <= show_an;
                            seg_q        <= show_seg;
                            frame_done_q <= wrap;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        an_q    <= '0;
                        seg_q   <= SEG_BLANK;
                    end
                endcase
            end
        end
    end

    // A load in the same cycle as a commit must survive as the new pending
    // value, so the load branch comes last and its assignments take effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (commit) begin
                disp_q       <= pend_q;
                pend_valid_q <= 1'b0;
            end
            if (load) begin
                pend_q       <= value_in;
                pend_valid_q <= 1'b1;
                if (load_bad) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (4 digits, 4-cycle slots, 1-cycle gaps):
// per-cycle expected outputs are queued per frame and popped as the DUT scans.
module tb_seven_seg_scan_ctrl;

    localparam int ND = 4;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        string      tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        err;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .value_in   (value_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_dec(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input logic [15:0] v, input int d, input logic blank);
        logic [3:0] n;
        logic       nz;
        n  = v[4*d +: 4];
        nz = 1'b0;
        for (int j = d; j < ND; j++) begin
            if (v[4*j +: 4] != 4'd0) nz = 1'b1;
        end
        if (n > 4'd9) return 7'h00;
        if (blank && (d > 0) && !nz) return 7'h00;
        return model_dec(n);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan frame: 4 digits x (4 SHOW cycles + 1 GAP cycle).
    task automatic push_frame(input string label, input logic [15:0] v, input logic blank,
                              input logic first);
        exp_t e;
        for (int t = 0; t < 20; t++) begin
            e.tag = $sformatf("%s t=%0d", label, t);
            if ((t % 5) < 4) begin
                e.an  = 4'(1 << (t / 5));
                e.seg = model_seg(v, t / 5, blank);
                e.fd  = (t == 0) && !first;
            end else begin
                e.an  = 4'd0;
                e.seg = 7'd0;
                e.fd  = 1'b0;
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            tick();
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL scoreboard_empty: observed=0 expected=>0");
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, " an"}, 16'(an), 16'(e.an));
                check({e.tag, " seg"}, 16'(seg), 16'(e.seg));
                check({e.tag, " frame_done"}, 16'(frame_done), 16'(e.fd));
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        load     = 1'b0;
        value_in = 16'h0000;
        blank_lz = 1'b0;
        tick();
        tick();
        check("reset an", 16'(an), 16'h0);
        check("reset seg", 16'(seg), 16'h0);
        check("reset frame_done", 16'(frame_done), 16'h0);
        check("reset err", 16'(err), 16'h0);

        // Load while dark: committed immediately in IDLE.
        rst      = 1'b0;
        load     = 1'b1;
        value_in = 16'h1234;
        tick();
        load = 1'b0;
        tick();
        check("idle an", 16'(an), 16'h0);
        enable = 1'b1;
        push_frame("f1234a", 16'h1234, 1'b0, 1'b1);
        drain(20);

        // Mid-frame load only appears after the wrap.
        push_frame("f1234b", 16'h1234, 1'b0, 1'b0);
        drain(6);
        load     = 1'b1;
        value_in = 16'h5678;
        drain(1);
        load = 1'b0;
        drain(13);
        push_frame("f5678", 16'h5678, 1'b0, 1'b0);
        drain(20);

        // Load sampled on the wrap edge waits a full frame.
        blank_lz = 1'b1;
        load     = 1'b1;
        value_in = 16'h0007;
        push_frame("f5678lz", 16'h5678, 1'b1, 1'b0);
        drain(1);
        load = 1'b0;
        drain(19);
        push_frame("f0007lz", 16'h0007, 1'b1, 1'b0);
        drain(10);
        load     = 1'b1;
        value_in = 16'h0000;
        drain(1);
        load = 1'b0;
        drain(9);
        push_frame("f0000lz", 16'h0000, 1'b1, 1'b0);
        drain(20);

        // Invalid nibble: sticky err, dark digit.
        check("err before bad load", 16'(err), 16'h0);
        blank_lz = 1'b0;
        load     = 1'b1;
        value_in = 16'h00A3;
        push_frame("f0000", 16'h0000, 1'b0, 1'b0);
        drain(1);
        load = 1'b0;
        check("err after 00A3", 16'(err), 16'h1);
        drain(19);
        load     = 1'b1;
        value_in = 16'h0001;
        push_frame("f00A3", 16'h00A3, 1'b0, 1'b0);
        drain(1);
        load = 1'b0;
        check("err after 0001", 16'(err), 16'h1);
        drain(10);

        // Disable during digit2 SHOW, then restart at digit0.
        enable = 1'b0;
        sb_q.delete();
        tick();
        check("disable an", 16'(an), 16'h0);
        check("disable seg", 16'(seg), 16'h0);
        check("disable frame_done", 16'(frame_done), 16'h0);
        tick();
        enable = 1'b1;
        push_frame("f0001", 16'h0001, 1'b0, 1'b1);
        drain(20);

        // Reset wins over a simultaneous load.
        rst      = 1'b1;
        load     = 1'b1;
        value_in = 16'hB999;
        tick();
        check("rst+load an", 16'(an), 16'h0);
        check("rst+load seg", 16'(seg), 16'h0);
        check("rst+load frame_done", 16'(frame_done), 16'h0);
        check("rst+load err", 16'(err), 16'h0);
        rst    = 1'b0;
        load   = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        check("post-rst err", 16'(err), 16'h0);
        enable = 1'b1;
        push_frame("fpostrst", 16'h0000, 1'b0, 1'b1);
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
